cmsdk_ahb_sram_bridge: RTL
==========================

CMSDK_AHB_SRAM_BRIDGE -- requirements
Module: cmsdk_ahb_sram_bridge

Interface
REQ-001 SHALL have parameter AW, default 16, AHB byte-address width; SRAM word-address width is AW-2.
REQ-002 SHALL have port HCLK  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port HRESETn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port HSEL  input  1  slave select.
REQ-005 SHALL have port HADDR  input  AW  byte address.
REQ-006 SHALL have port HTRANS  input  2  transfer type; bit 1 set = NONSEQ/SEQ.
REQ-007 SHALL have port HSIZE  input  3  transfer size.
REQ-008 SHALL have port HWRITE  input  1  1 = write.
REQ-009 SHALL have port HREADY  input  1  bus-wide ready.
REQ-010 SHALL have port HWDATA  input  32  write data, data phase.
REQ-011 SHALL have port HREADYOUT  output  1  slave ready.
REQ-012 SHALL have port HRDATA  output  32  read data, data phase.
REQ-013 SHALL have port HRESP  output  1  response, 0 = OKAY.
REQ-014 SHALL have port SRAMRDATA  input  32  SRAM read data, valid cycle after SRAMCS read; 0 when previous-cycle SRAMCS low.
REQ-015 SHALL have port SRAMADDR  output  AW-2  SRAM word address.
REQ-016 SHALL have port SRAMWEN  output  4  per-byte write enables.
REQ-017 SHALL have port SRAMWDATA  output  32  SRAM write data.
REQ-018 SHALL have port SRAMCS  output  1  SRAM chip select.

Function
REQ-019 SHALL define valid transfer = HSEL & HREADY & HTRANS[1]; address phase in that cycle, data phase next cycle.
REQ-020 SHALL derive byte mask: HSIZE 0 -> byte HADDR[1:0]; 1 -> halfword HADDR[1]; >=2 -> all four bytes.
REQ-021 SHALL drive HREADYOUT=1 and HRESP=0 at all times (zero wait states).
REQ-022 SHALL, on read address phase, drive SRAMCS=1, SRAMWEN=0, SRAMADDR=HADDR[AW-1:2] combinationally in that cycle; read has top SRAM priority.
REQ-023 SHALL, on write address phase, register word address and byte mask as wr_pend.
REQ-024 SHALL, in write data phase with no read address phase present, drive SRAMCS=1, SRAMWEN=mask, SRAMADDR=registered address, SRAMWDATA=HWDATA.
REQ-025 SHALL, in write data phase coincident with read address phase, load address, mask, HWDATA into one-entry buffer, buf_valid=1.
REQ-026 SHALL drain buffer in first later cycle without read address phase (SRAMCS=1, SRAMWEN=buf mask), clearing buf_valid same edge.
REQ-027 SHALL never need buffer and wr_pend SRAM write in one cycle (structurally exclusive); assertion required.
REQ-028 SHALL, in read data phase, return SRAMRDATA with bytes replaced by buffer bytes where buf_valid, address match, and mask bit set.
REQ-029 SHALL drive HRDATA=0 outside read data phases.
REQ-030 SHALL drive SRAMCS=0, SRAMWEN=0 in cycles with no SRAM access; SRAMADDR/SRAMWDATA don't-care then.
REQ-031 SHALL ignore transfers with HSEL=0 or HTRANS IDLE/BUSY; buffer drains regardless of HSEL.

Reset
REQ-032 SHALL, on HRESETn=0 at rising edge, clear wr_pend, rd_pend, buf_valid; SRAMCS=0, SRAMWEN=0, HRDATA=0 after that edge.
REQ-033 SHALL discard buffered or pending write on reset mid-operation; no SRAM write occurs.

Verification
REQ-034 SHALL cover: word write 0x10=0xA5A5A5A5 then idle -> SRAMCS=1, SRAMWEN=4'hF, SRAMADDR=0x4 in data phase; readback 0xA5A5A5A5.
REQ-035 SHALL cover: byte write 0x13=0x77 -> SRAMWEN=4'h8, other bytes unchanged on readback.
REQ-036 SHALL cover: write 0x20=0x12345678 followed immediately by read 0x20 -> buffer loaded, HRDATA=0x12345678 via merge, SRAM written next non-read cycle.
REQ-037 SHALL cover: W, R, R, R back-to-back -> buffer held through reads, drained first idle cycle, later read returns new data.
REQ-038 SHALL cover: HRESETn low cycle after buffer load -> buf_valid=0, SRAMWEN never asserted for that write.

Source files
------------

// File: rtl/cmsdk_ahb_sram_bridge.sv
// AHB-Lite to single-port SRAM bridge with zero wait states.
// Reads take the SRAM in their address phase, and a colliding write is parked in a one-entry buffer.
module cmsdk_ahb_sram_bridge #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP,
  input  logic [31:0]   SRAMRDATA,
  output logic [AW-3:0] SRAMADDR,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS
);

  localparam int WAW = AW - 2;

  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] m;
    if (size == 3'd0)      m = 4'b0001 << addr;
    else if (size == 3'd1) m = addr[1] ? 4'b1100 : 4'b0011;
    else                   m = 4'b1111;
    return m;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] sram, input logic [31:0] bdata,
                                              input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? bdata[8*i +: 8] : sram[8*i +: 8];
    return r;
  endfunction

  logic           trans_vld, rd_phase, wr_phase;
  logic           wr_direct, buf_load, buf_drain;
  logic [3:0]     mask_p0;
  logic           wr_pend, rd_pend, buf_valid;
  logic [WAW-1:0] wr_addr_p1, rd_addr_p1, buf_addr;
  logic [3:0]     wr_mask_p1, buf_mask, merge_sel;
  logic [31:0]    buf_data;
  logic           unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // Address phase decode. Nothing touches the SRAM while reset is asserted,
  // so a parked or pending write is lost rather than committed.
  assign trans_vld = HSEL & HREADY & HTRANS[1];
  assign rd_phase  = trans_vld & ~HWRITE & HRESETn;
  assign wr_phase  = trans_vld & HWRITE;
  assign mask_p0   = byte_mask(HSIZE, HADDR[1:0]);

  assign wr_direct = wr_pend & ~rd_phase & HRESETn;
  assign buf_load  = wr_pend & rd_phase;
  assign buf_drain = buf_valid & ~rd_phase & ~wr_pend & HRESETn;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      wr_pend <= wr_phase;
      rd_pend <= rd_phase;
      if (buf_load)       buf_valid <= 1'b1;
      else if (buf_drain) buf_valid <= 1'b0;
    end
  end

  // Data phase registers
  always_ff @(posedge HCLK) begin
    if (wr_phase) begin
      wr_addr_p1 <= HADDR[AW-1:2];
      wr_mask_p1 <= mask_p0;
    end
    if (rd_phase) rd_addr_p1 <= HADDR[AW-1:2];
    if (buf_load) begin
      buf_addr <= wr_addr_p1;
      buf_mask <= wr_mask_p1;
      buf_data <= HWDATA;
    end
  end

  // SRAM port priority: read address phase, then direct write, then buffer drain.
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = '0;
    SRAMWDATA = '0;
    if (rd_phase) begin
      SRAMCS   = 1'b1;
      SRAMADDR = HADDR[AW-1:2];
    end else if (wr_direct) begin
      SRAMCS    = 1'b1;
      SRAMWEN   = wr_mask_p1;
      SRAMADDR  = wr_addr_p1;
      SRAMWDATA = HWDATA;
    end else if (buf_drain) begin
      SRAMCS    = 1'b1;
      SRAMWEN   = buf_mask;
      SRAMADDR  = buf_addr;
      SRAMWDATA = buf_data;
    end
  end

  // A read of a word still sitting in the buffer must see the newer bytes.
  assign merge_sel = (buf_valid && (buf_addr == rd_addr_p1)) ? buf_mask : 4'b0000;
  assign HRDATA    = rd_pend ? merge_bytes(SRAMRDATA, buf_data, merge_sel) : 32'h0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // A write-pending cycle always follows a non-read cycle, which already drained the buffer.
  assert property (@(posedge HCLK) disable iff (!HRESETn) !(wr_pend && buf_valid));

endmodule
